// File: rtl/vout_capture_pkg.sv
// Shared defaults and the sample word type for the vout capture path.
package capture_pkg;

    localparam int V2KPARAM_DEF = 5;
    localparam int DEPTH_DEF    = 4;
    localparam int CNT_W_DEF    = 8;

    typedef logic [V2KPARAM_DEF:0] sample_t;

endpackage

// File: rtl/vout_capture_if.sv
// Valid/ready stream carrying captured vout samples to the next stage.
interface vout_capture_if #(
    parameter int WIDTH = capture_pkg::V2KPARAM_DEF + 1
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/vout_capture_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word; a push while full
// is still taken when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   level_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // The next head may be the word being written this very cycle, so it is
    // forwarded from din instead of waiting a cycle to read it back.
    always_comb begin
        rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        level_next  = level;
        if (do_push && !do_pop) begin
            level_next = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_next = level - 1'b1;
        end
        head_next = (do_push && (wr_ptr == rd_ptr_next)) ? din : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            if (level_next != '0) begin
                dout <= head_next;
            end
        end
    end

endmodule

// File: rtl/vout_capture.sv
// Captures strobed vout samples into a FIFO, streams them out, counts accepted
// samples and flags any sample dropped because the FIFO was full.
module vout_capture
    import capture_pkg::*;
#(
    parameter int V2KPARAM = V2KPARAM_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [V2KPARAM:0]      vout_i,
    input  logic                   sample_i,
    vout_capture_if.master         stream,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [CNT_W-1:0]       sample_cnt
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             accepted;
    logic [V2KPARAM:0] fifo_dout;

    assign pop      = stream.out_valid & stream.out_ready;
    assign drop     = sample_i & fifo_full & ~pop;
    assign accepted = sample_i & ~drop;

    assign stream.out_valid = ~fifo_empty;
    assign stream.out_data  = fifo_dout;

    sync_fifo #(
        .WIDTH (V2KPARAM + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_i),
        .din   (vout_i),
        .pop   (stream.out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (accepted) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vout_capture.sv
// Scoreboard bench for vout_capture: expected samples are queued as they are
// driven and compared as the stream presents them.
module tb_vout_capture;
    import capture_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] vout_i = '0;
    logic       sample_i = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] level;
    logic       overflow;
    logic [3:0] sample_cnt;

    vout_capture_if #(.WIDTH(6)) bus ();

    vout_capture #(
        .V2KPARAM (5),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vout_i     (vout_i),
        .sample_i   (sample_i),
        .stream     (bus),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    sample_t q[$];
    bit      model_ovf = 1'b0;
    int      model_cnt = 0;
    int      n_accepted = 0;
    int      check_cnt = 0;
    int      pass_cnt = 0;
    bit      held = 1'b0;
    sample_t held_data = '0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_state();
        check_output("level", 32'(level), 32'(q.size()));
        check_output("overflow", 32'(overflow), 32'(model_ovf));
        check_output("sample_cnt", 32'(sample_cnt), 32'(model_cnt));
    endtask

    // One clock of stimulus: check the presented head before the edge, advance
    // the model across the edge, then check the registered state after it.
    task automatic apply_stimulus(input logic s, input logic [5:0] v,
                                  input logic rdy, input logic clr);
        bit pop;
        bit accept;
        @(negedge clk);
        rst      = 1'b0;
        sample_i = s;
        vout_i   = v;
        bus.out_ready = rdy;
        clr_ovf  = clr;
        #1;
        check_output("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_output("out_data", 32'(bus.out_data), 32'(q[0]));
        end
        if (held && q.size() != 0) begin
            check_output("stable", 32'(bus.out_data), 32'(held_data));
        end
        pop    = (q.size() != 0) && rdy;
        accept = s && ((q.size() < DEPTH) || pop);
        held   = (q.size() != 0) && !rdy;
        if (q.size() != 0) begin
            held_data = q[0];
        end
        if (s && !accept) begin
            model_ovf = 1'b1;
        end else if (clr) begin
            model_ovf = 1'b0;
        end
        if (pop) begin
            void'(q.pop_front());
        end
        if (accept) begin
            q.push_back(v);
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            n_accepted++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic reset_dut(input logic s, input logic [5:0] v);
        @(negedge clk);
        rst      = 1'b1;
        sample_i = s;
        vout_i   = v;
        bus.out_ready = 1'b1;
        clr_ovf  = 1'b0;
        q.delete();
        model_ovf = 1'b0;
        model_cnt = 0;
        held      = 1'b0;
        @(posedge clk);
        #1;
        check_state();
        check_output("rst_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_data", 32'(bus.out_data), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) begin
            apply_stimulus(1'b0, 6'h00, 1'b1, 1'b0);
        end
        check_output("drained", 32'(q.size()), 32'd0);
        apply_stimulus(1'b0, 6'h00, 1'b1, 1'b0);
    endtask

    task automatic fill_four();
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 6'(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;

        reset_dut(1'b0, 6'h00);
        apply_stimulus(1'b1, 6'h2A, 1'b0, 1'b0);
        apply_stimulus(1'b0, 6'h00, 1'b0, 1'b0);
        check_output("first_data", 32'(bus.out_data), 32'h2A);
        drain();

        reset_dut(1'b0, 6'h00);
        fill_four();
        apply_stimulus(1'b1, 6'h05, 1'b0, 1'b0);
        check_output("drop_ovf", 32'(overflow), 32'd1);
        drain();

        reset_dut(1'b0, 6'h00);
        fill_four();
        apply_stimulus(1'b1, 6'h3F, 1'b1, 1'b0);
        check_output("full_swap_level", 32'(level), 32'd4);
        drain();

        fill_four();
        apply_stimulus(1'b1, 6'h07, 1'b0, 1'b1);
        check_output("set_wins", 32'(overflow), 32'd1);
        apply_stimulus(1'b0, 6'h00, 1'b0, 1'b1);
        check_output("clear", 32'(overflow), 32'd0);
        drain();

        reset_dut(1'b0, 6'h00);
        n_accepted = 0;
        for (int i = 0; i < 100 && n_accepted < 17; i++) begin
            apply_stimulus(q.size() < DEPTH, 6'($urandom_range(0, 63)), (i % 2) == 0, 1'b0);
        end
        check_output("wrap_accepted", 32'(n_accepted), 32'd17);
        check_output("wrap_cnt", 32'(sample_cnt), 32'd1);
        drain();

        reset_dut(1'b0, 6'h00);
        fill_four();
        apply_stimulus(1'b1, 6'h11, 1'b0, 1'b0);
        apply_stimulus(1'b0, 6'h00, 1'b1, 1'b0);
        check_output("pre_rst_level", 32'(level), 32'd3);
        reset_dut(1'b1, 6'h22);
        apply_stimulus(1'b0, 6'h00, 1'b0, 1'b0);
        check_output("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
